pixel_packer: RTL and testbench

//  Downstream stage of the ray-march shading pipeline (after coord_counter).

---
 rtl/pixel_packer.sv | 218 +++++++++++++++++++++
 tb/tb_pixel_packer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// pixel_packer: packs PIXEL_W-bit shade values into DATA_W-bit AXI4-Stream words.
// sof_in is carried on tuser and eol_in on tlast. A first-word-fall-through FIFO
// with a registered head entry absorbs consumer backpressure, because upstream
// cannot be stalled. When the FIFO is full an incoming word is dropped and a
// sticky overflow flag is set.
// Optional build macro PIXEL_PACKER_STATS_EN adds the frame_count and drop_count outputs.
module pixel_packer #(
  parameter int unsigned PIXEL_W    = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_gen,
  input  logic [PIXEL_W-1:0]            shade_in,
  input  logic                          valid_in,
  input  logic                          sof_in,
  input  logic                          eol_in,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic                          proto_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PIXEL_PACKER_STATS_EN
  ,
  output logic [15:0]                   frame_count,
  output logic [15:0]                   drop_count
`endif
);

  localparam int unsigned PPW    = DATA_W / PIXEL_W;
  localparam int unsigned LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Pack stage state
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              acc_sof_q, acc_sof_d;

  // FIFO state: head register feeds the stream, mem holds the words behind it
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            out_q, out_d;
  logic              out_vld_q, out_vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  logic [LANE_W-1:0] eff_lane;
  logic [DATA_W-1:0] base_acc;
  logic [DATA_W-1:0] acc_w;
  logic              word_sof;
  logic              sof_err;
  logic              push;
  entry_t            push_entry;
  logic              full;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              head_free;
  logic [CNT_W-1:0]  mem_cnt;
  logic              mem_we;

  // Pack stage: place the pixel in its lane, decide word completion
  always_comb begin
    eff_lane  = lane_q;
    base_acc  = acc_q;
    sof_err   = 1'b0;
    lane_d    = lane_q;
    acc_d     = acc_q;
    acc_sof_d = acc_sof_q;
    // A frame start with a partial word pending discards that word
    if (sof_in && (lane_q != '0)) begin
      eff_lane = '0;
      base_acc = '0;
      sof_err  = valid_in;
    end
    acc_w = base_acc;
    for (int k = 0; k < int'(PPW); k++) begin
      if (LANE_W'(k) == eff_lane) begin
        acc_w[k*PIXEL_W +: PIXEL_W] = shade_in;
      end
    end
    word_sof   = (eff_lane == '0) ? sof_in : acc_sof_q;
    push       = valid_in & ((eff_lane == LANE_W'(PPW - 1)) | eol_in);
    push_entry = '{tuser: word_sof, tlast: eol_in, data: acc_w};
    if (valid_in) begin
      if (push) begin
        lane_d    = '0;
        acc_d     = '0;
        acc_sof_d = 1'b0;
      end else begin
        lane_d    = eff_lane + LANE_W'(1);
        acc_d     = acc_w;
        acc_sof_d = word_sof;
      end
    end
  end

  // FIFO control: refill the head from mem first, else straight from the pack stage
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = out_vld_q & m_axis_tready;
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
    mem_cnt   = count_q - CNT_W'(out_vld_q);
    head_free = ~out_vld_q | pop;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    mem_we    = 1'b0;
    if (head_free) begin
      if (mem_cnt != '0) begin
        out_vld_d = 1'b1;
        out_d     = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_d     = push_entry;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    if (accept && !(head_free && (mem_cnt == '0))) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  // Sticky flags: a set event in the same cycle overrides the clear
  always_comb begin
    overflow_d  = ovf_clr ? 1'b0 : overflow_q;
    proto_err_d = ovf_clr ? 1'b0 : proto_err_q;
    if (drop)    overflow_d  = 1'b1;
    if (sof_err) proto_err_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_gen) begin
    if (!rst_gen) begin
      lane_q      <= '0;
      acc_q       <= '0;
      acc_sof_q   <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      acc_sof_q   <= acc_sof_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO storage; contents are only meaningful under the pointers, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_entry;
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.tuser;
  assign m_axis_tlast  = out_q.tlast;
  assign m_axis_tvalid = out_vld_q;
  assign fifo_level    = count_q;
  assign overflow      = overflow_q;
  assign proto_err     = proto_err_q;

`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating frame and drop counters
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (pop && out_q.tuser && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (drop && (drop_cnt_q != 16'hFFFF))                drop_cnt_d  = drop_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_gen) begin
    if (!rst_gen) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (PIXEL_W=8, DATA_W=32, FIFO_DEPTH=16).
module tb_pixel_packer;

  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_gen;
  logic [PIXEL_W-1:0] shade_in;
  logic               valid_in, sof_in, eol_in;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic               ovf_clr, overflow, proto_err;
  logic [4:0]         fifo_level;
`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0]        frame_count, drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] exp_q[$];
  logic [33:0] prev_out;
  logic [33:0] cur_out;
  bit          stall;

  pixel_packer #(.PIXEL_W(PIXEL_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_gen(rst_gen), .shade_in(shade_in), .valid_in(valid_in),
    .sof_in(sof_in), .eol_in(eol_in), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .ovf_clr(ovf_clr),
    .overflow(overflow), .proto_err(proto_err), .fifo_level(fifo_level)
`ifdef PIXEL_PACKER_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel on one clock edge; returns #1 after the edge
  task automatic pix(input logic [7:0] s, input bit sof, input bit eol);
    shade_in = s; valid_in = 1'b1; sof_in = sof; eol_in = eol;
    @(posedge clk); #1;
    valid_in = 1'b0; sof_in = 1'b0; eol_in = 1'b0; shade_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One cycle with random tready, checking popped words and stall stability
  task automatic step4(input bit v, input logic [7:0] s, input bit sof, input bit eol);
    valid_in = v; shade_in = s; sof_in = sof; eol_in = eol;
    m_axis_tready = 1'($urandom_range(0, 1));
    cur_out = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (stall) begin
      chk("t4_hold_valid", 64'(m_axis_tvalid), 64'd1);
      chk("t4_hold_word", 64'(cur_out), 64'(prev_out));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) chk("t4_unexpected_word", 64'd1, 64'd0);
      else chk("t4_word", 64'(cur_out), 64'(exp_q.pop_front()));
    end
    stall    = m_axis_tvalid && !m_axis_tready;
    prev_out = cur_out;
    @(posedge clk); #1;
    valid_in = 1'b0; sof_in = 1'b0; eol_in = 1'b0; shade_in = '0;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] acc;
    logic [7:0]  s;
    int          guard;

    rst_gen = 1'b0; shade_in = '0; valid_in = 1'b0; sof_in = 1'b0; eol_in = 1'b0;
    m_axis_tready = 1'b0; ovf_clr = 1'b0; stall = 1'b0; prev_out = '0; cur_out = '0;
    idle(2);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tuser_tlast", 64'({m_axis_tuser, m_axis_tlast}), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_flags", 64'({overflow, proto_err}), 64'd0);
    rst_gen = 1'b1;
    idle(1);

    // Single full word with sof and eol
    m_axis_tready = 1'b1;
    pix(8'h11, 1, 0); pix(8'h22, 0, 0); pix(8'h33, 0, 0); pix(8'h44, 0, 1);
    chk("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_tdata", 64'(m_axis_tdata), 64'h44332211);
    chk("t1_tuser", 64'(m_axis_tuser), 64'd1);
    chk("t1_tlast", 64'(m_axis_tlast), 64'd1);
    chk("t1_level", 64'(fifo_level), 64'd1);
    idle(1);
    chk("t1_drained", 64'({m_axis_tvalid, fifo_level}), 64'd0);

    // Six-pixel line: full word then zero-padded partial word
    pix(8'h01, 0, 0); pix(8'h02, 0, 0); pix(8'h03, 0, 0); pix(8'h04, 0, 0);
    chk("t2_w0_data", 64'(m_axis_tdata), 64'h04030201);
    chk("t2_w0_user_last", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'b100);
    pix(8'h05, 0, 0); pix(8'h06, 0, 1);
    chk("t2_w1_data", 64'(m_axis_tdata), 64'h00000605);
    chk("t2_w1_user_last", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'b101);
    idle(1);

    // Fill to full with tready low, 17th word dropped
    m_axis_tready = 1'b0;
    for (int w = 0; w < 17; w++) begin
      for (int k = 0; k < 4; k++) pix(8'(4*w + k), 0, 0);
      if (w == 15) begin
        chk("t3_level_full", 64'(fifo_level), 64'd16);
        chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
      end
    end
    chk("t3_level_after", 64'(fifo_level), 64'd16);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_proto", 64'(proto_err), 64'd0);
`ifdef PIXEL_PACKER_STATS_EN
    chk("t3_drop_count", 64'(drop_count), 64'd1);
`endif
    m_axis_tready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      e = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
      chk("t3_pop_valid", 64'(m_axis_tvalid), 64'd1);
      chk("t3_pop_data", 64'(m_axis_tdata), 64'(e));
      idle(1);
    end
    chk("t3_empty", 64'({m_axis_tvalid, fifo_level}), 64'd0);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("t3_ovf_cleared", 64'(overflow), 64'd0);

    // 64x4 frame with random backpressure against a word model
    acc = '0;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 64; p++) begin
        s = 8'($urandom_range(0, 255));
        acc[(p % 4)*8 +: 8] = s;
        if ((p % 4) == 3) exp_q.push_back({(l == 0 && p == 3), (p == 63), acc});
        step4(1'b1, s, (l == 0 && p == 0), (p == 63));
      end
    end
    guard = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 400) begin
      step4(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    chk("t4_all_popped", 64'(exp_q.size()), 64'd0);
    m_axis_tready = 1'b1; stall = 1'b0;
    idle(1);
    chk("t4_empty", 64'({m_axis_tvalid, fifo_level}), 64'd0);

    // sof with a partial word pending
    pix(8'h01, 0, 0); pix(8'h02, 0, 0);
    chk("t5_no_err_yet", 64'(proto_err), 64'd0);
    pix(8'hAA, 1, 0);
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    chk("t5_partial_discarded", 64'(m_axis_tvalid), 64'd0);
    pix(8'hBB, 0, 0); pix(8'hCC, 0, 0); pix(8'hDD, 0, 0);
    chk("t5_data", 64'(m_axis_tdata), 64'hDDCCBBAA);
    chk("t5_user_last", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'b110);
    idle(1);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("t5_cleared", 64'(proto_err), 64'd0);
    pix(8'h01, 0, 0);
    ovf_clr = 1'b1; pix(8'h55, 1, 0); ovf_clr = 1'b0;
    chk("t5_set_wins", 64'(proto_err), 64'd1);
    pix(8'h66, 0, 1);
    chk("t5_w2_data", 64'(m_axis_tdata), 64'h00006655);
    chk("t5_w2_user_last", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'b111);
    idle(1);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("t5_cleared2", 64'(proto_err), 64'd0);

    // Async reset mid-word with words queued
    m_axis_tready = 1'b0;
    for (int i = 0; i < 12; i++) pix(8'(8'hC0 + i), 0, 0);
    pix(8'hE1, 0, 0); pix(8'hE2, 0, 0); pix(8'hE3, 1, 0);
    chk("t6_level_before", 64'(fifo_level), 64'd3);
    chk("t6_err_before", 64'(proto_err), 64'd1);
    #2 rst_gen = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    chk("t6_rst_flags", 64'({overflow, proto_err}), 64'd0);
    @(posedge clk); #1;
    rst_gen = 1'b1; m_axis_tready = 1'b1;
    pix(8'h77, 0, 0); pix(8'h88, 0, 1);
    chk("t6_restart_data", 64'(m_axis_tdata), 64'h00008877);
    chk("t6_restart_user_last", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 64'b101);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
